car_detect: RTL and testbench

CAR_DETECT -- requirements
Module: car_detect

---
 rtl/trafficlight_pkg.sv | 28 ++
 rtl/sensor_debounce.sv | 53 +++++
 rtl/car_detect.sv | 149 ++++++++++++++
 tb/tb_car_detect.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/trafficlight_pkg.sv
// trafficlight_pkg: shared definitions for the side-road car detector.
//   - car_state_e : request FSM states
//   - LIGHT_*     : one-hot lamp codes within a 3-bit {R,Y,G} group
//   - slice bounds for the main and side groups of the 6-bit light bus
//   - light_code_legal() : true when a 3-bit group holds exactly one lamp
package trafficlight_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StServed = 2'd2,
        StFault  = 2'd3
    } car_state_e;

    localparam logic [2:0] LIGHT_G = 3'b001;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b100;

    localparam int unsigned LIGHT_MAIN_MSB = 5;
    localparam int unsigned LIGHT_MAIN_LSB = 3;
    localparam int unsigned LIGHT_SIDE_MSB = 2;
    localparam int unsigned LIGHT_SIDE_LSB = 0;

    function automatic logic light_code_legal(input logic [2:0] code);
        return (code == LIGHT_G) || (code == LIGHT_Y) || (code == LIGHT_R);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer followed by a consecutive-sample debouncer.
// Ports:
//   clk          in  system clock, rising edge
//   rst          in  asynchronous active-high reset
//   i_sensor_raw in  asynchronous loop-detector level
//   o_presence   out debounced presence (registered)
// Presence changes only after the synchronized level has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module sensor_debounce
    import trafficlight_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sensor_raw,
    output logic o_presence
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_presence;
    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_presence <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1 <= i_sensor_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_presence) begin
                // The count never passes DEBOUNCE_CYCLES-1, so it cannot wrap.
                if (r_cnt == CntLast) begin
                    r_presence <= r_sync2;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_presence = r_presence;

endmodule

// File: rtl/car_detect.sv
// car_detect: side-road vehicle detector and service-request FSM.
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-high reset
//   sensor_raw in  asynchronous loop level, 1 = vehicle present
//   light      in  lamps: [5:3] main {R,Y,G}, [2:0] side {R,Y,G}
//   car        out registered side-road service request
//   fault      out registered stuck-sensor indication
//   light_err  out registered one-cycle pulse for an illegal light code
//   wait_cnt   out cycles spent in REQ (only with CAR_DETECT_WAIT_CNT_EN)
// Optional feature macro: CAR_DETECT_WAIT_CNT_EN adds the wait_cnt output.
module car_detect
    import trafficlight_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned STUCK_CYCLES    = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sensor_raw,
    input  logic [5:0]  light,
    output logic        car,
    output logic        fault,
    output logic        light_err
`ifdef CAR_DETECT_WAIT_CNT_EN
    ,
    output logic [15:0] wait_cnt
`endif
);

    localparam int unsigned StuckW = $clog2(STUCK_CYCLES + 1);
    localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES);

    car_state_e        r_state;
    logic              r_car;
    logic              r_fault;
    logic              r_light_err;
    logic [StuckW-1:0] r_stuck_cnt;

    logic              w_presence;
    logic [2:0]        w_main;
    logic [2:0]        w_side;
    logic              w_light_ok;
    logic              w_side_green;
    logic              w_side_red;
    logic [StuckW-1:0] w_stuck_next;
    logic              w_stuck_hit;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .i_sensor_raw(sensor_raw),
        .o_presence  (w_presence)
    );

    assign w_main = light[LIGHT_MAIN_MSB:LIGHT_MAIN_LSB];
    assign w_side = light[LIGHT_SIDE_MSB:LIGHT_SIDE_LSB];

    // An illegal code in either group hides the whole bus from the FSM this cycle.
    assign w_light_ok   = light_code_legal(w_main) && light_code_legal(w_side);
    assign w_side_green = w_light_ok && (w_side == LIGHT_G);
    assign w_side_red   = w_light_ok && (w_side == LIGHT_R);

    always_comb begin
        w_stuck_next = (r_stuck_cnt == StuckMax) ? StuckMax : r_stuck_cnt + 1'b1;
        w_stuck_hit  = (r_state == StReq) && w_presence && (w_stuck_next == StuckMax);
    end

    // Presence run length, only meaningful while a request is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stuck_cnt <= '0;
        end else if ((r_state == StReq) && w_presence) begin
            r_stuck_cnt <= w_stuck_next;
        end else begin
            r_stuck_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_car       <= 1'b0;
            r_fault     <= 1'b0;
            r_light_err <= 1'b0;
        end else begin
            r_light_err <= ~w_light_ok;
            case (r_state)
                StIdle: begin
                    if (w_presence) begin
                        r_state <= StReq;
                        r_car   <= 1'b1;
                    end
                end
                StReq: begin
                    // Presence dropping here does not cancel the latched request.
                    if (w_side_green) begin
                        r_state <= StServed;
                        r_car   <= 1'b0;
                    end else if (w_stuck_hit) begin
                        r_state <= StFault;
                        r_car   <= 1'b0;
                        r_fault <= 1'b1;
                    end
                end
                StServed: begin
                    if (w_side_red) begin
                        r_state <= StIdle;
                    end
                end
                StFault: begin
                    if (!w_presence) begin
                        r_state <= StIdle;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_car   <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign car       = r_car;
    assign fault     = r_fault;
    assign light_err = r_light_err;

`ifdef CAR_DETECT_WAIT_CNT_EN
    logic [15:0] r_wait_cnt;

    // Cleared on the IDLE->REQ transition, held outside REQ, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if ((r_state == StIdle) && w_presence) begin
            r_wait_cnt <= '0;
        end else if ((r_state == StReq) && (r_wait_cnt != 16'hFFFF)) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign wait_cnt = r_wait_cnt;
`endif

endmodule

// File: tb/tb_car_detect.sv
// tb_car_detect: randomized and directed bench for car_detect with a
// sliding-window / flag-based reference model.
module tb_car_detect;

    localparam int unsigned DEB   = 16;
    localparam int unsigned STUCK = 50;

    localparam logic [5:0] L_MAIN_GO = 6'b001100;  // main green, side red
    localparam logic [5:0] L_SIDE_GO = 6'b100001;  // main red, side green

    logic       clk;
    logic       rst;
    logic       sensor_raw;
    logic [5:0] light;
    logic       car;
    logic       fault;
    logic       light_err;
`ifdef CAR_DETECT_WAIT_CNT_EN
    logic [15:0] wait_cnt;
`endif

    int n_tests;
    int n_fail;

    car_detect #(
        .DEBOUNCE_CYCLES(DEB),
        .STUCK_CYCLES   (STUCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_raw(sensor_raw),
        .light     (light),
        .car       (car),
        .fault     (fault),
        .light_err (light_err)
`ifdef CAR_DETECT_WAIT_CNT_EN
        ,
        .wait_cnt  (wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_d1, m_d2;        // raw level one and two edges back
    bit m_win[$];          // most recent synchronized samples, up to DEB of them
    bit m_pres;
    bit m_car, m_fault, m_wait_red, m_lerr;
    int m_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit onehot3(input logic [2:0] v);
        return $countones(v) == 1;
    endfunction

    task automatic model_reset();
        m_d1 = 0; m_d2 = 0; m_win.delete();
        m_pres = 0; m_car = 0; m_fault = 0; m_wait_red = 0; m_lerr = 0; m_run = 0;
    endtask

    task automatic model_edge(input bit raw, input logic [5:0] l);
        bit s, lok, green, red, flip;
        s = m_d2;
        m_d2 = m_d1;
        m_d1 = raw;
        lok   = onehot3(l[5:3]) && onehot3(l[2:0]);
        green = lok && (l[2:0] == 3'b001);
        red   = lok && (l[2:0] == 3'b100);
        // Request behaviour, decided on the presence seen before this edge.
        if (m_fault) begin
            m_run = 0;
            if (!m_pres) m_fault = 0;
        end else if (m_car) begin
            if (m_pres) m_run++; else m_run = 0;
            if (green) begin
                m_car = 0; m_wait_red = 1;
            end else if (m_run >= STUCK) begin
                m_car = 0; m_fault = 1;
            end
        end else if (m_wait_red) begin
            m_run = 0;
            if (red) m_wait_red = 0;
        end else begin
            m_run = 0;
            if (m_pres) m_car = 1;
        end
        m_lerr = !lok;
        // Presence flips once the last DEB synchronized samples all disagree.
        m_win.push_back(s);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        flip = (m_win.size() == DEB);
        foreach (m_win[i]) if (m_win[i] == m_pres) flip = 0;
        if (flip) m_pres = s;
    endtask

    task automatic step(input bit raw, input logic [5:0] l);
        sensor_raw = raw;
        light = l;
        @(posedge clk);
        model_edge(raw, l);
        #1;
        check("car", car, m_car);
        check("fault", fault, m_fault);
        check("light_err", light_err, m_lerr);
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        #1;
        check("rst_car", car, 0);
        check("rst_fault", fault, 0);
        check("rst_light_err", light_err, 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int n;
        int len;
        int r;
        bit raw;
        logic [5:0] lr;
        n_tests = 0;
        n_fail = 0;
        clk = 0;
        rst = 0;
        sensor_raw = 0;
        light = L_MAIN_GO;
        model_reset();
        #2;
        do_reset();
        repeat (5) step(0, L_MAIN_GO);

        // Step 0->1: car rises 2 + DEB + 1 cycles later
        n = 0;
        do begin step(1, L_MAIN_GO); n++; end while (!car && n < 40);
        check("latency_car_rise", n, 2 + DEB + 1);

        // Presence drop in REQ keeps the request until side green
        repeat (25) step(0, L_MAIN_GO);
        check("req_latched", car, 1);
        step(0, L_SIDE_GO);
        check("served_car_drop", car, 0);

        // Car present while served: re-request two cycles after the red
        repeat (22) step(1, L_SIDE_GO);
        check("served_hold", car, 0);
        step(1, L_MAIN_GO);
        check("red_to_idle", car, 0);
        step(1, L_MAIN_GO);
        check("rerequest", car, 1);

        // Stuck sensor
        n = 0;
        do begin step(1, L_MAIN_GO); n++; end while (!fault && n < 80);
        check("stuck_cycles", n, STUCK);
        check("fault_car", car, 0);
        n = 0;
        do begin step(0, L_MAIN_GO); n++; end while (fault && n < 40);
        check("fault_release", n, 2 + DEB + 1);

        // Illegal light code
        step(0, 6'b011100);
        check("lerr_pulse", light_err, 1);
        step(0, L_MAIN_GO);
        check("lerr_clear", light_err, 0);
        n = 0;
        do begin step(1, L_MAIN_GO); n++; end while (!car && n < 40);
        check("latency_again", n, 2 + DEB + 1);
        step(1, 6'b011001);  // side green hidden by an illegal main group
        check("illegal_ignored", car, 1);
        step(1, L_MAIN_GO);

        // Reset in REQ, no memory afterwards
        sensor_raw = 0;
        do_reset();
        repeat (30) step(0, L_MAIN_GO);
        check("no_memory", car, 0);

        // Short pulse is filtered
        repeat (10) step(1, L_MAIN_GO);
        repeat (30) step(0, L_MAIN_GO);
        check("glitch_car", car, 0);

        // Randomized segments
        for (int seg = 0; seg < 150; seg++) begin
            raw = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 90));
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: lr = L_MAIN_GO;
                4, 5, 6:    lr = L_SIDE_GO;
                7:          lr = 6'b010100;
                8:          lr = 6'b100010;
                default:    lr = 6'($urandom);
            endcase
            if (r == 9) begin
                step(raw, lr);
                lr = L_MAIN_GO;
            end
            for (int k = 0; k < len; k++) step(raw, lr);
            if ($urandom_range(0, 40) == 0) begin
                sensor_raw = raw;
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
